multicycle_cpu: RTL and testbench
=================================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter DATA_W, default 8: register, ALU and result width in bits.
REQ-002 Parameter REG_AW, default 2: register-address width; register file holds 2**REG_AW entries.
REQ-003 Parameter IMEM_AW, default 4: instruction-memory address width; depth 2**IMEM_AW. INST_W = 2+3*REG_AW, format {op, src1, src2, dest}, MSB first.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse; begins execution at pc 0.
REQ-007 imem_we / imem_addr / imem_wdata  in  1 / IMEM_AW / INST_W  instruction-memory write port.
REQ-008 rf_we / rf_addr / rf_wdata  in  1 / REG_AW / DATA_W  register-file preload port.
REQ-009 inst_out  out  INST_W  current instruction register.
REQ-010 result_out  out  DATA_W  last written-back result.
REQ-011 pc_out  out  IMEM_AW  current program counter.
REQ-012 busy  out  1  high in FETCH/DECODE/EXEC/WB.
REQ-013 halted  out  1  high in HALT.
REQ-014 retire  out  1  one-cycle pulse in the WB cycle.

Function
REQ-015 FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT; one cycle each for FETCH/DECODE/EXEC/WB, so 4 cycles per instruction.
REQ-016 IDLE or HALT with start=1 -> FETCH with pc=0; otherwise hold state.
REQ-017 FETCH: inst register <= imem[pc]; DECODE: operand registers <= rf[src1], rf[src2]; EXEC: ALU register <= f(op, a, b); WB: rf[dest] <= ALU register, result_out <= ALU register, retire=1.
REQ-018 Ops: 00 ADD, 01 SUB (a-b), 10 AND, 11 OR; all results wrap mod 2**DATA_W with no carry/borrow output.
REQ-019 After WB: pc = 2**IMEM_AW-1 -> HALT with pc held; else pc increments and FSM goes to FETCH.
REQ-020 imem_we and rf_we are honoured only in IDLE or HALT; while busy they are ignored and memory contents are unchanged.
REQ-021 rf_we and start in the same cycle: the write completes, and the program sees the new value.
REQ-022 start while busy is ignored.
REQ-023 dest equal to src1 or src2: operands were sampled in DECODE, so the WB write does not affect the current instruction; the next instruction's DECODE sees the new value.
REQ-024 Reading instruction memory or registers before any write returns 0.

Reset
REQ-025 reset overrides all inputs, including mid-instruction: state=IDLE, pc=0, inst_out=0, result_out=0, busy=0, halted=0, retire=0, all registers=0.
REQ-026 Instruction-memory contents are not cleared by reset; a program survives reset.

Configuration
REQ-027 Macro MULTICYCLE_CPU_MUL_EN defined: op 11 = MUL, returning the low DATA_W bits of a*b.
REQ-028 Macro MULTICYCLE_CPU_MUL_EN undefined: op 11 = OR and no multiplier is synthesised; all other behaviour is identical.

Verification
REQ-029 Defaults; preload r0=3, r1=5; imem[0]=ADD r0,r1->r2; start -> retire exactly 4 cycles after FETCH entry, result_out=8, r2=8.
REQ-030 Preload r0=2, r1=5; SUB r0,r1->r3 -> result_out=8'hFD; with r0=8'hFF, r1=1, ADD -> 8'h00.
REQ-031 Chain: imem[0]=ADD r0,r1->r0, imem[1]=ADD r0,r0->r0 with r0=1, r1=1 -> results 2, then 4.
REQ-032 Full program of 16 instructions -> 16 retire pulses, halted=1, pc_out=15; a second start re-runs from pc 0.
REQ-033 Assert reset during EXEC -> next cycle busy=0, pc_out=0, result_out=0; a later start re-executes the same program from imem.
REQ-034 rf_we and imem_we while busy -> no change; with MULTICYCLE_CPU_MUL_EN, 8'h10*8'h11 -> 8'h10; without the macro, op 11 on the same operands -> 8'h11.

Source files
------------

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: four-cycle-per-instruction CPU (FETCH, DECODE, EXEC, WB) with a
// preloadable register file and a writable instruction memory.
// Instruction format {op[1:0], src1, src2, dest}, MSB first.
// Optional feature: define MULTICYCLE_CPU_MUL_EN to turn op 11 into MUL (low DATA_W
// bits of a*b). The default build keeps op 11 as OR, and no multiplier is built.
module multicycle_cpu #(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 2,
    parameter int IMEM_AW = 4,
    localparam int INST_W = 2 + 3 * REG_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_addr,
    input  logic [INST_W-1:0]  imem_wdata,
    input  logic               rf_we,
    input  logic [REG_AW-1:0]  rf_addr,
    input  logic [DATA_W-1:0]  rf_wdata,
    output logic [INST_W-1:0]  inst_out,
    output logic [DATA_W-1:0]  result_out,
    output logic [IMEM_AW-1:0] pc_out,
    output logic               busy,
    output logic               halted,
    output logic               retire
);

    localparam int RF_DEPTH   = 1 << REG_AW;
    localparam int IMEM_DEPTH = 1 << IMEM_AW;
    localparam logic [IMEM_AW-1:0] PC_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [IMEM_AW-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]    inst_q;
    logic [DATA_W-1:0]    a_q, b_q, alu_q, result_q;
    logic [DATA_W-1:0]    rf_q   [RF_DEPTH];
    logic [INST_W-1:0]    imem_q [IMEM_DEPTH];
    logic                 idle_like;

    logic [1:0]           op;
    logic [REG_AW-1:0]    src1, src2, dest;

    assign op   = inst_q[INST_W-1 -: 2];
    assign src1 = inst_q[3*REG_AW-1 -: REG_AW];
    assign src2 = inst_q[2*REG_AW-1 -: REG_AW];
    assign dest = inst_q[REG_AW-1:0];

    // ALU: every result wraps modulo 2**DATA_W; no carry or borrow is kept.
    function automatic logic [DATA_W-1:0] alu_f(input logic [1:0]        op_f,
                                                input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] r;
        case (op_f)
            2'b00:   r = x + y;
            2'b01:   r = x - y;
            2'b10:   r = x & y;
`ifdef MULTICYCLE_CPU_MUL_EN
            default: r = x * y;
`else
            default: r = x | y;
`endif
        endcase
        return r;
    endfunction

    // State and program-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic, pc sequencing and status outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        idle_like = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                idle_like = 1'b1;
                halted    = (state_q == S_HALT);
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                busy   = 1'b1;
                retire = 1'b1;
                if (pc_q == PC_LAST) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + IMEM_AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: instruction register, operand latches, ALU result and register file.
    // Operands are captured in DECODE, so a WB to src1/src2 only affects later instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            result_q <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (state_q == S_FETCH) begin
                inst_q <= imem_q[pc_q];
            end
            if (state_q == S_DECODE) begin
                a_q <= rf_q[src1];
                b_q <= rf_q[src2];
            end
            if (state_q == S_EXEC) begin
                alu_q <= alu_f(op, a_q, b_q);
            end
            if (state_q == S_WB) begin
                rf_q[dest] <= alu_q;
                result_q   <= alu_q;
            end else if (rf_we && idle_like) begin
                rf_q[rf_addr] <= rf_wdata;
            end
        end
    end

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && imem_we && idle_like) begin
            imem_q[imem_addr] <= imem_wdata;
        end
    end

    assign inst_out   = inst_q;
    assign result_out = result_q;
    assign pc_out     = pc_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu (default parameters). A behavioural model
// executes each program with plain arithmetic and queues one expectation per retire;
// a monitor pops and compares whenever the CPU retires an instruction.
module tb_multicycle_cpu;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       imem_we;
    logic [3:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       rf_we;
    logic [1:0] rf_addr;
    logic [7:0] rf_wdata;
    logic [7:0] inst_out;
    logic [7:0] result_out;
    logic [3:0] pc_out;
    logic       busy;
    logic       halted;
    logic       retire;

    multicycle_cpu dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .inst_out(inst_out), .result_out(result_out), .pc_out(pc_out),
        .busy(busy), .halted(halted), .retire(retire)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pc;
        logic [7:0] inst;
        logic [7:0] res;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] imem_m [16];
    logic [7:0] rf_m   [4];
    int         checks = 0;
    int         errors = 0;
    int         retire_cnt = 0;
    bit         pend = 1'b0;
    logic [7:0] pend_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mk(input int op, input int s1, input int s2, input int d);
        return 8'((op << 6) | (s1 << 4) | (s2 << 2) | d);
    endfunction

    // Reference model: run all 16 slots from pc 0, queueing one result per slot.
    function automatic void model_run();
        for (int p = 0; p < 16; p++) begin
            logic [7:0] i;
            int a, b, r;
            i = imem_m[p];
            a = int'(rf_m[i[5:4]]);
            b = int'(rf_m[i[3:2]]);
            case (i[7:6])
                2'd0: r = (a + b) % 256;
                2'd1: r = (a - b + 256) % 256;
                2'd2: r = a & b;
`ifdef MULTICYCLE_CPU_MUL_EN
                default: r = (a * b) % 256;
`else
                default: r = a | b;
`endif
            endcase
            rf_m[i[1:0]] = r[7:0];
            exp_q.push_back('{pc: p, inst: i, res: r[7:0]});
        end
    endfunction

    // Monitor: compare pc/instruction at each retire, then the written-back result a cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            chk("result_out", 32'(result_out), 32'(pend_res));
            pend = 1'b0;
        end
        if (retire) begin
            retire_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire actual pc=%0d required=no retire", pc_out);
            end else begin
                e = exp_q.pop_front();
                chk("retire_pc", 32'(pc_out), 32'(e.pc));
                chk("retire_inst", 32'(inst_out), 32'(e.inst));
                pend     = 1'b1;
                pend_res = e.res;
            end
        end
    end

    task automatic imem_write(input int addr, input logic [7:0] data);
        imem_we    = 1'b1;
        imem_addr  = 4'(addr);
        imem_wdata = data;
        @(negedge clk);
        imem_we    = 1'b0;
        imem_m[addr] = data;
    endtask

    task automatic rf_write(input int addr, input logic [7:0] data);
        rf_we    = 1'b1;
        rf_addr  = 2'(addr);
        rf_wdata = data;
        @(negedge clk);
        rf_we    = 1'b0;
        rf_m[addr] = data;
    endtask

    task automatic fill_random_imem(input int from);
        for (int p = from; p < 16; p++) imem_write(p, 8'($urandom));
    endtask

    // Start a full program run and follow it to HALT with bounded waits.
    task automatic run_prog(input string tag, input int first_exp, input bit disturb,
                            input bit do_wr, input int wr_addr, input logic [7:0] wr_data);
        int n;
        int base;
        if (do_wr) begin
            rf_we    = 1'b1;
            rf_addr  = 2'(wr_addr);
            rf_wdata = wr_data;
            rf_m[wr_addr] = wr_data;
        end
        model_run();
        base  = retire_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rf_we = 1'b0;
        chk({tag, "_busy_fetch"}, 32'(busy), 32'd1);
        n = 1;
        while (!retire && n < 8) begin
            if (disturb && n == 2) begin
                rf_we      = 1'b1;
                rf_addr    = 2'($urandom_range(3));
                rf_wdata   = 8'($urandom);
                imem_we    = 1'b1;
                imem_addr  = 4'($urandom_range(15));
                imem_wdata = 8'($urandom);
                start      = 1'b1;
            end
            @(negedge clk);
            n++;
            rf_we   = 1'b0;
            imem_we = 1'b0;
            start   = 1'b0;
        end
        chk({tag, "_retire_latency"}, 32'(n), 32'd4);
        if (first_exp >= 0) begin
            @(negedge clk);
            chk({tag, "_first_result"}, 32'(result_out), 32'(first_exp));
        end
        n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_busy_halt"}, 32'(busy), 32'd0);
        chk({tag, "_pc_halt"}, 32'(pc_out), 32'd15);
        chk({tag, "_retire_count"}, 32'(retire_cnt - base), 32'd16);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] mul_exp;
        reset = 1'b1; start = 1'b0;
        imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        rf_we = 1'b0; rf_addr = '0; rf_wdata = '0;
        for (int i = 0; i < 4; i++) rf_m[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_inst", 32'(inst_out), 32'd0);
        chk("rst_result", 32'(result_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD r0,r1->r2 with r0=3, r1=5
        imem_write(0, mk(0, 0, 1, 2));
        fill_random_imem(1);
        rf_write(0, 8'd3);
        rf_write(1, 8'd5);
        rf_write(2, 8'd0);
        rf_write(3, 8'd0);
        run_prog("add", 8, 1'b0, 1'b0, 0, 8'd0);

        // SUB r0,r1->r3 with r0=2, r1=5 wraps to FD
        imem_write(0, mk(1, 0, 1, 3));
        rf_write(0, 8'd2);
        rf_write(1, 8'd5);
        run_prog("sub", 8'hFD, 1'b0, 1'b0, 0, 8'd0);

        // ADD FF+1 wraps to 00
        imem_write(0, mk(0, 0, 1, 2));
        rf_write(0, 8'hFF);
        rf_write(1, 8'h01);
        run_prog("add_wrap", 8'h00, 1'b0, 1'b0, 0, 8'd0);

        // Dependent chain: r0=r0+r1 then r0=r0+r0 gives 2 then 4
        imem_write(0, mk(0, 0, 1, 0));
        imem_write(1, mk(0, 0, 0, 0));
        rf_write(0, 8'd1);
        rf_write(1, 8'd1);
        run_prog("chain", 2, 1'b0, 1'b0, 0, 8'd0);

        // Second start from HALT re-runs from pc 0
        run_prog("rerun", -1, 1'b0, 1'b0, 0, 8'd0);

        // op 11 on 10h and 11h: MUL or OR depending on build
`ifdef MULTICYCLE_CPU_MUL_EN
        mul_exp = 8'h10;
`else
        mul_exp = 8'h11;
`endif
        imem_write(0, mk(3, 0, 1, 2));
        rf_write(0, 8'h10);
        rf_write(1, 8'h11);
        run_prog("op3", int'(mul_exp), 1'b0, 1'b0, 0, 8'd0);

        // Writes and start while busy are ignored
        fill_random_imem(0);
        run_prog("busy_writes", -1, 1'b1, 1'b0, 0, 8'd0);

        // rf write in the same cycle as start is seen by the program
        imem_write(0, mk(0, 2, 2, 1));
        run_prog("wr_with_start", 8'h42, 1'b0, 1'b1, 2, 8'h21);

        // Reset during EXEC of the third instruction, then rerun from a cleared register file
        fill_random_imem(0);
        for (int i = 0; i < 4; i++) rf_write(i, 8'($urandom));
        model_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pc", 32'(pc_out), 32'd0);
        chk("midrst_result", 32'(result_out), 32'd0);
        chk("midrst_inst", 32'(inst_out), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 4; i++) rf_m[i] = '0;
        run_prog("after_reset", -1, 1'b0, 1'b0, 0, 8'd0);

        // Randomised programs and register contents
        for (int k = 0; k < 4; k++) begin
            fill_random_imem(0);
            for (int i = 0; i < 4; i++) rf_write(i, 8'($urandom));
            run_prog("random", -1, k[0], 1'b0, 0, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
